// File: rtl/reaction_meter_if.sv
// Player-side bundle of the reaction meter: round control and stimulus
// inputs plus the result/status outputs. The meter takes the slave view.
interface reaction_meter_if #(
  parameter int W = 12
);
  logic         arm;
  logic         go;
  logic         btn;
  logic         busy;
  logic         valid;
  logic         early;
  logic         timeout;
  logic [W-1:0] time_ms;
  logic [W-1:0] best_ms;

  modport master (
    output arm, go, btn,
    input  busy, valid, early, timeout, time_ms, best_ms
  );

  modport slave (
    input  arm, go, btn,
    output busy, valid, early, timeout, time_ms, best_ms
  );
endinterface

// File: rtl/reaction_meter.sv
// Reaction meter: once the stimulus LED turns on, counts 1 ms ticks until
// the player's synchronised button edge, flags early presses and timeouts,
// and tracks the best valid time since reset.
module reaction_meter #(
  parameter int W      = 12,
  parameter int MAX_MS = 1999
) (
  input  logic             clk1k,
  input  logic             rst_n,
  reaction_meter_if.slave  bus
);

  localparam logic [W-1:0] MAX_C = W'(MAX_MS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GO,
    TIMING,
    DONE,
    EARLY,
    TOUT
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] time_q, time_d;
  logic [W-1:0] best_q, best_d;
  logic         s1_q, s2_q, prev_q;
  logic         btn_rise;

  // The raw button is asynchronous; s1/s2 resynchronise it, prev finds the edge.
  assign btn_rise = s2_q & ~prev_q;

  // State, counter, results and button flops, all with synchronous reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk1k) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      time_q  <= '0;
      best_q  <= '1;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      best_q  <= best_d;
      s1_q    <= bus.btn;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
    end
  end

  // Next-state logic: arm restarts from anywhere, otherwise walk the round.
  always_comb begin
    // NOTE: defaults first so every path assigns every target (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    time_d  = time_q;
    best_d  = best_q;

    if (bus.arm) begin
      state_d = WAIT_GO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_GO: begin
          if (btn_rise) begin
            state_d = EARLY;
          end else if (bus.go) begin
            state_d = TIMING;
            cnt_d   = '0;
          end
        end
        TIMING: begin
          if (btn_rise) begin
            state_d = DONE;
            time_d  = cnt_q;
            if (cnt_q < best_q) best_d = cnt_q;
          end else if (cnt_q == MAX_C) begin
            // Compare before increment so the counter can never wrap.
            state_d = TOUT;
            time_d  = MAX_C;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          // IDLE, DONE, EARLY, TOUT hold until the next arm.
        end
      endcase
    end
  end

  // Status flags are decoded straight from the state register.
  assign bus.busy    = (state_q == WAIT_GO) || (state_q == TIMING);
  assign bus.valid   = (state_q == DONE);
  assign bus.early   = (state_q == EARLY);
  assign bus.timeout = (state_q == TOUT);
  assign bus.time_ms = time_q;
  assign bus.best_ms = best_q;

endmodule

// File: tb/tb_reaction_meter.sv
// Bench for reaction_meter: directed rounds plus randomized rounds, each
// predicted from edge arithmetic on when go and the button are first seen.
module tb_reaction_meter;

  localparam int W   = 12;
  localparam int MAX = 1999;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   exp_time;
  int   exp_best;

  reaction_meter_if #(.W(W)) rm_if ();

  reaction_meter #(.W(W), .MAX_MS(MAX)) dut (
    .clk1k (clk),
    .rst_n (rst_n),
    .bus   (rm_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge; returns at the following falling edge, where outputs
  // reflect edge number cyc and new inputs will be seen by edge cyc+1.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int v, input int e, input int t);
    check({tag, "/valid"},   32'(rm_if.valid),   32'(v));
    check({tag, "/early"},   32'(rm_if.early),   32'(e));
    check({tag, "/timeout"}, 32'(rm_if.timeout), 32'(t));
    check({tag, "/busy"},    32'(rm_if.busy),    32'd0);
    check({tag, "/time"},    32'(rm_if.time_ms), 32'(exp_time));
    check({tag, "/best"},    32'(rm_if.best_ms), 32'(exp_best));
  endtask

  // Arm, then go first seen go_delay edges later, button first seen btn_off
  // edges after go. btn_rise lands two edges after the button is first seen,
  // so the reaction time is btn_off+1; negative means early, past MAX means
  // timeout at MAX+1 edges after go.
  task automatic run_round(input int go_delay, input int btn_off, input string tag);
    int a, g, b, r, t, delta;
    bit is_early, is_done;
    rm_if.arm = 1'b1;
    rm_if.go  = 1'b0;
    rm_if.btn = 1'b0;
    step();
    a = cyc;
    rm_if.arm = 1'b0;
    check({tag, "/armed_busy"}, 32'(rm_if.busy), 32'd1);
    check({tag, "/armed_flags"},
          32'({rm_if.valid, rm_if.early, rm_if.timeout}), 32'd0);
    check({tag, "/armed_time"}, 32'(rm_if.time_ms), 32'(exp_time));

    g = a + go_delay;
    b = g + btn_off;
    r = b + 2;
    delta = btn_off + 1;
    is_early = (delta < 0);
    is_done  = !is_early && (delta <= MAX);
    t = (is_early || is_done) ? r : g + MAX + 1;

    while (cyc < t + 1) begin
      int e;
      e = cyc + 1;
      rm_if.go  = (e >= g);
      rm_if.btn = (e >= b) && (e < b + 3);
      step();
    end
    rm_if.go  = 1'b0;
    rm_if.btn = 1'b0;

    if (is_done) begin
      exp_time = delta;
      if (delta < exp_best) exp_best = delta;
    end else if (!is_early) begin
      exp_time = MAX;
    end
    check_result(tag, int'(is_done), int'(is_early), int'(!is_early && !is_done));
    repeat (3) step();
  endtask

  initial begin
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    rm_if.arm = 1'b0;
    rm_if.go  = 1'b0;
    rm_if.btn = 1'b0;
    repeat (2) step();
    rst_n    = 1'b1;
    exp_time = 0;
    exp_best = 'hFFF;
    check_result("reset", 0, 0, 0);

    // T1: 252 ms reaction straight after reset.
    run_round(9, 251, "t1");

    // T2: early press, then a fresh arm clears early at once.
    run_round(50, -20, "t2");
    rm_if.arm = 1'b1;
    step();
    rm_if.arm = 1'b0;
    check("t2/rearm_early", 32'(rm_if.early), 32'd0);
    check("t2/rearm_busy",  32'(rm_if.busy),  32'd1);

    // T3: no press gives timeout; a late press changes nothing.
    run_round(5, 3000, "t3");
    rm_if.btn = 1'b1;
    repeat (4) step();
    rm_if.btn = 1'b0;
    step();
    check("t3/late_timeout", 32'(rm_if.timeout), 32'd1);
    check("t3/late_time",    32'(rm_if.time_ms), 32'(MAX));
    check("t3/late_valid",   32'(rm_if.valid),   32'd0);

    // T4: best tracks the minimum; reset restores all ones.
    run_round(7, 299, "t4a");
    run_round(12, 179, "t4b");
    run_round(3, 239, "t4c");
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    exp_time = 0;
    exp_best = 'hFFF;
    check_result("t4/reset", 0, 0, 0);

    // T5: arm during TIMING at cnt=100 discards silently; the new round
    // then sees go and btn_rise on the same edge, which is an early press.
    rm_if.arm = 1'b1;
    step();
    rm_if.arm = 1'b0;
    rm_if.go  = 1'b1;
    step();
    repeat (100) step();
    check("t5/timing_busy", 32'(rm_if.busy), 32'd1);
    rm_if.go = 1'b0;
    run_round(10, -2, "t5b");

    // T6: arm held together with btn_rise while in DONE.
    run_round(4, 119, "t6pre");
    rm_if.btn = 1'b1;
    step();
    step();
    rm_if.arm = 1'b1;
    step();
    check("t6/valid_clear", 32'(rm_if.valid), 32'd0);
    check("t6/early_clear", 32'(rm_if.early), 32'd0);
    check("t6/busy",        32'(rm_if.busy),  32'd1);
    repeat (2) step();
    rm_if.arm = 1'b0;
    rm_if.btn = 1'b0;
    repeat (3) step();
    check("t6/still_wait", 32'(rm_if.busy),    32'd1);
    check("t6/time_kept",  32'(rm_if.time_ms), 32'(exp_time));
    check("t6/best_kept",  32'(rm_if.best_ms), 32'(exp_best));

    // Boundaries: zero time, exactly MAX, one past MAX.
    run_round(5, -1, "b_zero");
    run_round(5, MAX - 1, "b_max");
    run_round(5, MAX, "b_over");

    // Randomized rounds: a mix of early presses and valid reactions.
    for (int i = 0; i < 16; i++) begin
      int gd, off;
      gd = int'($urandom_range(3, 40));
      if ($urandom_range(0, 9) < 3) off = -int'($urandom_range(2, gd - 1));
      else                          off = int'($urandom_range(0, 400)) - 1;
      run_round(gd, off, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
